parity_frame_serializer: RTL and testbench

Upstream feeder for the serial parity-checking stage. Accepts parallel words over a valid/ready handshake and shifts each one out LSB-first, one bit per clock, followed by one generated parity bit. Frame boundary strobes let the downstream checker align its per-sequence evaluation. Words are streamed back-to-back with no idle gap while input is available.

---
 rtl/parity_frame_serializer.sv | 127 ++++++++++++
 tb/tb_parity_frame_serializer.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/parity_frame_serializer.sv
// parity_frame_serializer
//
// Takes parallel words over a valid/ready handshake. Each word is shifted
// out LSB-first, one bit per clock. A generated parity bit follows the last
// data bit. Words stream back-to-back with no idle gap while input keeps
// coming, so a frame (WIDTH data bits plus one parity bit) lasts WIDTH+1
// cycles.
//
// Parameters
//   WIDTH  data word width in bits (>= 2)
//   ODD    0 = even parity, 1 = odd parity over data+parity
//
// Ports
//   clk          system clock, rising edge
//   reset        asynchronous active-high reset to idle
//   in_data      parallel word, sampled only at the accept edge
//   in_valid     in_data is valid
//   in_ready     word can be accepted this cycle (IDLE or PARITY)
//   ser_out      serial data/parity bit (registered, 0 when not valid)
//   ser_valid    ser_out carries a frame bit (registered)
//   frame_first  ser_out is data bit 0 of a frame (registered)
//   frame_last   ser_out is the parity bit of a frame (registered)
module parity_frame_serializer #(
    parameter int WIDTH = 3,
    parameter bit ODD   = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             ser_out,
    output logic             ser_valid,
    output logic             frame_first,
    output logic             frame_last
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2
    } state_t;

    state_t           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [WIDTH-1:0] shift_q;
    logic             par_q;
    logic             ser_out_q;
    logic             ser_valid_q;
    logic             first_q;
    logic             last_q;

    logic             accept_d;
    logic             par_d;

    // The parity cycle also accepts, which is what removes the gap between frames.
    assign in_ready = (state_q != DATA);
    assign accept_d = in_valid && in_ready;
    assign par_d    = (^in_data) ^ ODD;

    assign ser_out     = ser_out_q;
    assign ser_valid   = ser_valid_q;
    assign frame_first = first_q;
    assign frame_last  = last_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            shift_q     <= '0;
            par_q       <= 1'b0;
            ser_out_q   <= 1'b0;
            ser_valid_q <= 1'b0;
            first_q     <= 1'b0;
            last_q      <= 1'b0;
        end else begin
            case (state_q)
                IDLE, PARITY: begin
                    if (accept_d) begin
                        // Bit 0 goes straight to the output; the shift register
                        // keeps the remaining bits, aligned so bit 1 sits at [0].
                        state_q     <= DATA;
                        cnt_q       <= '0;
                        shift_q     <= {1'b0, in_data[WIDTH-1:1]};
                        par_q       <= par_d;
                        ser_out_q   <= in_data[0];
                        ser_valid_q <= 1'b1;
                        first_q     <= 1'b1;
                        last_q      <= 1'b0;
                    end else begin
                        state_q     <= IDLE;
                        ser_out_q   <= 1'b0;
                        ser_valid_q <= 1'b0;
                        first_q     <= 1'b0;
                        last_q      <= 1'b0;
                    end
                end
                DATA: begin
                    first_q     <= 1'b0;
                    ser_valid_q <= 1'b1;
                    // cnt_q is the index of the bit currently on ser_out.
                    if (cnt_q == LAST_CNT) begin
                        state_q   <= PARITY;
                        ser_out_q <= par_q;
                        last_q    <= 1'b1;
                    end else begin
                        ser_out_q <= shift_q[0];
                        shift_q   <= {1'b0, shift_q[WIDTH-1:1]};
                        cnt_q     <= cnt_q + 1'b1;
                        last_q    <= 1'b0;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    ser_out_q   <= 1'b0;
                    ser_valid_q <= 1'b0;
                    first_q     <= 1'b0;
                    last_q      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_parity_frame_serializer.sv
module tb_parity_frame_serializer;

    localparam int W = 3;

    logic         clk;
    logic         reset;
    logic [W-1:0] in_data;
    logic         in_valid;

    logic rdy_e, out_e, vld_e, ff_e, fl_e;
    logic rdy_o, out_o, vld_o, ff_o, fl_o;

    parity_frame_serializer #(.WIDTH(W), .ODD(1'b0)) u_even (
        .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
        .in_ready(rdy_e), .ser_out(out_e), .ser_valid(vld_e),
        .frame_first(ff_e), .frame_last(fl_e)
    );

    parity_frame_serializer #(.WIDTH(W), .ODD(1'b1)) u_odd (
        .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
        .in_ready(rdy_o), .ser_out(out_o), .ser_valid(vld_o),
        .frame_first(ff_o), .frame_last(fl_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected serial stream, one entry per frame cycle.
    typedef struct packed {
        logic b_even;
        logic b_odd;
        logic first;
        logic last;
    } exp_t;

    exp_t sb[$];
    int   rem;        // frame cycles still to present, including the current one
    int   checks;
    int   errors;
    logic [31:0] cap_e, cap_o;
    int   ncap;
    int   run_len, max_run;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference model: on every accepted word, queue its bits and parity.
    always @(posedge clk) begin
        if (reset) begin
            sb.delete();
            rem = 0;
        end else if (in_valid && rem <= 1) begin
            for (int i = 0; i < W; i++)
                sb.push_back('{in_data[i], in_data[i], (i == 0), 1'b0});
            sb.push_back('{^in_data, ~(^in_data), 1'b0, 1'b1});
            rem = W + 1;
        end else if (rem > 0) begin
            rem = rem - 1;
        end
    end

    // Monitor: compares DUT outputs against the scoreboard away from the active edge.
    always @(negedge clk) begin
        exp_t e;
        if (reset) begin
            chk("reset_outputs", {22'd0, vld_e, vld_o, out_e, out_o, ff_e, ff_o, fl_e, fl_o, rdy_e, rdy_o},
                32'b11);
        end else begin
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("frame_even", {28'd0, vld_e, out_e, ff_e, fl_e}, {28'd0, 1'b1, e.b_even, e.first, e.last});
                chk("frame_odd",  {28'd0, vld_o, out_o, ff_o, fl_o}, {28'd0, 1'b1, e.b_odd,  e.first, e.last});
            end else begin
                chk("idle_outputs", {24'd0, vld_e, out_e, ff_e, fl_e, vld_o, out_o, ff_o, fl_o}, 32'd0);
            end
            chk("in_ready", {30'd0, rdy_e, rdy_o}, {30'd0, {2{rem <= 1}}});
            if (vld_e) begin
                cap_e = {cap_e[30:0], out_e};
                cap_o = {cap_o[30:0], out_o};
                ncap++;
                run_len++;
                if (run_len > max_run) max_run = run_len;
            end else begin
                run_len = 0;
            end
        end
    end

    task automatic clear_cap();
        cap_e = '0;
        cap_o = '0;
        ncap  = 0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Present a word and hold it until accepted; waited = cycles in_ready was low.
    task automatic send(input logic [W-1:0] w, input bit hold, output int waited);
        waited   = 0;
        in_data  = w;
        in_valid = 1'b1;
        forever begin
            @(negedge clk);
            if (rdy_e) break;
            waited++;
            if (waited > 50) begin
                chk("accept_timeout", 32'd1, 32'd0);
                break;
            end
        end
        @(posedge clk);
        #1;
        if (!hold) in_valid = 1'b0;
    endtask

    // Assert reset mid-cycle and confirm outputs clear without a clock edge.
    task automatic reset_mid();
        @(negedge clk);
        #2;
        reset = 1'b1;
        sb.delete();
        rem = 0;
        #1;
        chk("async_reset", {22'd0, vld_e, vld_o, out_e, out_o, ff_e, ff_o, fl_e, fl_o, rdy_e, rdy_o}, 32'b11);
        clear_cap();
        repeat (2) @(posedge clk);
        @(negedge clk);
        #2;
        reset = 1'b0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int waited;
        int gap;
        checks   = 0;
        errors   = 0;
        rem      = 0;
        run_len  = 0;
        max_run  = 0;
        reset    = 1'b1;
        in_valid = 1'b0;
        in_data  = '0;
        clear_cap();
        #3;
        chk("reset_at_start", {22'd0, vld_e, vld_o, out_e, out_o, ff_e, ff_o, fl_e, fl_o, rdy_e, rdy_o}, 32'b11);
        repeat (2) @(posedge clk);
        @(negedge clk);
        #2;
        reset = 1'b0;
        idle(2);

        // Single word 101: 1,0,1 then parity
        clear_cap();
        send(3'b101, 1'b0, waited);
        idle(6);
        chk("single_101_even", cap_e, 32'b1010);
        chk("single_101_odd",  cap_o, 32'b1011);
        chk("single_101_len",  ncap, 4);

        // Parity sense
        clear_cap();
        send(3'b111, 1'b0, waited);
        idle(6);
        chk("par_111_even", cap_e, 32'b1111);
        chk("par_111_odd",  cap_o, 32'b1110);
        clear_cap();
        send(3'b000, 1'b0, waited);
        idle(6);
        chk("par_000_even", cap_e, 32'b0000);
        chk("par_000_odd",  cap_o, 32'b0001);
        clear_cap();
        send(3'b110, 1'b0, waited);
        idle(6);
        chk("par_110_even", cap_e, 32'b0110);
        chk("par_110_odd",  cap_o, 32'b0111);

        // Sweep 0..7 with in_valid held
        max_run = 0;
        clear_cap();
        for (int w = 0; w < 8; w++) begin
            send(W'(w), (w != 7), waited);
            if (w > 0) chk("sweep_wait", waited, W);
        end
        idle(8);
        chk("sweep_run", max_run, 32);
        chk("sweep_bits", ncap, 32);

        // Input stability: in_data changes during DATA with valid high
        clear_cap();
        send(3'b011, 1'b1, waited);
        in_data = 3'b100;
        send(3'b100, 1'b0, waited);
        chk("stable_accept_at_parity", waited, W);
        idle(8);
        chk("stable_frames_even", cap_e, 32'b1100_0011);
        chk("stable_frames_odd",  cap_o, 32'b1101_0010);

        // Reset mid-frame after bit 1 of 110
        send(3'b110, 1'b0, waited);
        @(posedge clk);
        reset_mid();
        idle(2);
        send(3'b001, 1'b0, waited);
        idle(6);
        chk("after_reset_even", cap_e, 32'b1001);
        chk("after_reset_odd",  cap_o, 32'b1000);
        chk("after_reset_len",  ncap, 4);

        // Randomized traffic
        for (int k = 0; k < 40; k++) begin
            gap = $urandom_range(0, 3);
            if (gap > 0) begin
                in_valid = 1'b0;
                idle(gap);
            end
            send(W'($urandom_range(0, 7)), ($urandom_range(0, 1) == 1), waited);
        end
        in_valid = 1'b0;
        idle(10);
        chk("scoreboard_drained", sb.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
